// File: rtl/bounce_generator.sv
// bounce_generator: contact-bounce emulator, the inverse of a debouncer.
// After every level change on clean_i it emits a pseudo-random burst of toggles on
// bounced_o for BOUNCE_CYCLES cycles, then settles to the new level.
//
// Ports:
//   clock          system clock
//   resetn         synchronous active-low reset
//   enable_i       1 = bounce emulation on, 0 = registered bypass
//   clean_i        clean level to emulate
//   bounced_o      emulated bouncy contact signal
//   busy_o         high while a bounce window is active
//   glitch_count_o saturating count of transitions made inside bounce windows
//                  (present only when BOUNCE_GEN_GLITCH_COUNT_EN is defined)
//
// Optional feature macro: BOUNCE_GEN_GLITCH_COUNT_EN
module bounce_generator #(
   parameter int unsigned BOUNCE_CYCLES = 5000,
   parameter int unsigned MIN_HOLD      = 8,
   parameter int unsigned HOLD_BITS     = 6,
   parameter logic [15:0] SEED          = 16'hACE1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        enable_i,
   input  logic        clean_i,
   output logic        bounced_o,
   output logic        busy_o
`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
   ,
   output logic [15:0] glitch_count_o
`endif
);

   localparam int unsigned WinW  = $clog2(BOUNCE_CYCLES);
   localparam int unsigned HoldW = HOLD_BITS + $clog2(MIN_HOLD + 1);

   localparam logic [WinW-1:0]  WinLoad = WinW'(BOUNCE_CYCLES - 1);
   localparam logic [WinW-1:0]  WinOne  = WinW'(1);
   localparam logic [HoldW-1:0] HoldMin = HoldW'(MIN_HOLD);
   localparam logic [HoldW-1:0] HoldOne = HoldW'(1);
   // An all-zero seed would lock the LFSR up.
   localparam logic [15:0]      SeedEff = (SEED == 16'h0000) ? 16'hACE1 : SEED;

   typedef enum logic [0:0] {StIdle, StBounce} state_e;

   state_e           state_q, state_d;
   logic             level_q, level_d;
   logic             target_q, target_d;
   logic             bounced_q, bounced_d;
   logic [WinW-1:0]  win_cnt_q, win_cnt_d;
   logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [HoldW-1:0] hold_load;

   // Galois LFSR, x^16+x^14+x^13+x^11+1; free-running whenever out of reset.
   assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   assign hold_load = HoldMin + HoldW'(lfsr_q[HOLD_BITS-1:0]);

   // State register
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= StIdle;
         level_q    <= 1'b0;
         target_q   <= 1'b0;
         bounced_q  <= 1'b0;
         win_cnt_q  <= '0;
         hold_cnt_q <= '0;
         lfsr_q     <= SeedEff;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         target_q   <= target_d;
         bounced_q  <= bounced_d;
         win_cnt_q  <= win_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         lfsr_q     <= lfsr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      target_d   = target_q;
      bounced_d  = bounced_q;
      win_cnt_d  = win_cnt_q;
      hold_cnt_d = hold_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (!enable_i) begin
               bounced_d = clean_i;
               level_d   = clean_i;
            end else if (clean_i != level_q) begin
               target_d   = clean_i;
               bounced_d  = clean_i;
               win_cnt_d  = WinLoad;
               hold_cnt_d = hold_load;
               state_d    = StBounce;
            end
         end
         StBounce: begin
            if (!enable_i) begin
               bounced_d = clean_i;
               level_d   = clean_i;
               state_d   = StIdle;
            end else if (clean_i != target_q) begin
               // Reversal restarts the whole window towards the new level.
               target_d   = clean_i;
               win_cnt_d  = WinLoad;
               hold_cnt_d = hold_load;
               bounced_d  = ~bounced_q;
            end else if (win_cnt_q == '0) begin
               // Forced settle regardless of toggle parity.
               bounced_d = target_q;
               level_d   = target_q;
               state_d   = StIdle;
            end else begin
               win_cnt_d = win_cnt_q - WinOne;
               if (hold_cnt_q == '0) begin
                  bounced_d  = ~bounced_q;
                  hold_cnt_d = hold_load;
               end else begin
                  hold_cnt_d = hold_cnt_q - HoldOne;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs, all straight from registers
   always_comb begin
      busy_o    = (state_q == StBounce);
      bounced_o = bounced_q;
   end

`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
   logic [15:0] glitch_q, glitch_d;

   // Counts any output change made in a window, including entry and the final settle.
   always_comb begin
      glitch_d = glitch_q;
      if ((state_q == StBounce || state_d == StBounce) && (bounced_d != bounced_q) &&
          (glitch_q != 16'hFFFF)) begin
         glitch_d = glitch_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         glitch_q <= 16'h0000;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_count_o = glitch_q;
`endif

endmodule

// File: tb/tb_bounce_generator.sv
// Testbench for bounce_generator. A reference model driven by absolute cycle
// timestamps predicts the outputs at every clock edge and pushes them into a
// queue; a monitor on the falling edge pops and compares against the DUT.
module tb_bounce_generator;

   localparam int unsigned BC = 100;
   localparam int unsigned MH = 4;
   localparam int unsigned HB = 3;
   localparam logic [15:0] SD = 16'hACE1;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        enable_i = 1'b1;
   logic        clean_i = 1'b0;
   logic        bounced_o;
   logic        busy_o;
   logic [15:0] glitch_count_o;

   bounce_generator #(
      .BOUNCE_CYCLES (BC),
      .MIN_HOLD      (MH),
      .HOLD_BITS     (HB),
      .SEED          (SD)
   ) dut (
      .clock          (clock),
      .resetn         (resetn),
      .enable_i       (enable_i),
      .clean_i        (clean_i),
      .bounced_o      (bounced_o),
      .busy_o         (busy_o)
`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
      ,
      .glitch_count_o (glitch_count_o)
`endif
   );

`ifndef BOUNCE_GEN_GLITCH_COUNT_EN
   assign glitch_count_o = 16'h0000;
`endif

   always #10 clock = ~clock;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_total++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        b;
      logic        busy;
      logic [15:0] g;
   } exp_t;

   exp_t sb_q[$];

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   function automatic int hold_of(input logic [15:0] l);
      return int'(MH) + int'(l % (16'd1 << HB));
   endfunction

   initial begin : model
      logic        m_busy, m_level, m_target, m_out, prev, was_busy;
      logic [15:0] m_lfsr;
      int          m_cyc, m_win_end, m_next_tog, m_glitch;
      exp_t        e;
      m_busy = 0; m_level = 0; m_target = 0; m_out = 0; m_lfsr = SD;
      m_cyc = 0; m_win_end = 0; m_next_tog = 0; m_glitch = 0;
      forever begin
         @(posedge clock);
         m_cyc++;
         if (!resetn) begin
            m_busy = 0; m_level = 0; m_target = 0; m_out = 0;
            m_lfsr = SD; m_glitch = 0;
         end else begin
            prev     = m_out;
            was_busy = m_busy;
            if (!m_busy) begin
               if (!enable_i) begin
                  m_out = clean_i; m_level = clean_i;
               end else if (clean_i != m_level) begin
                  m_target   = clean_i;
                  m_out      = clean_i;
                  m_busy     = 1;
                  m_win_end  = m_cyc + int'(BC);
                  m_next_tog = m_cyc + hold_of(m_lfsr) + 1;
               end
            end else if (!enable_i) begin
               m_out = clean_i; m_level = clean_i; m_busy = 0;
            end else if (clean_i != m_target) begin
               m_target   = clean_i;
               m_out      = ~m_out;
               m_win_end  = m_cyc + int'(BC);
               m_next_tog = m_cyc + hold_of(m_lfsr) + 1;
            end else if (m_cyc == m_win_end) begin
               m_out = m_target; m_level = m_target; m_busy = 0;
            end else if (m_cyc == m_next_tog) begin
               m_out      = ~m_out;
               m_next_tog = m_cyc + hold_of(m_lfsr) + 1;
            end
            if ((was_busy || m_busy) && (m_out != prev) && m_glitch < 65535) m_glitch++;
            m_lfsr = lfsr_next(m_lfsr);
         end
         e.b    = m_out;
         e.busy = m_busy;
         e.g    = 16'(m_glitch);
         sb_q.push_back(e);
      end
   end

   // ---------------- monitor ----------------
   int   busy_cnt  = 0;
   int   tog_total = 0;
   int   last_tog  = -1;
   int   mon_cyc   = 0;
   logic mon_prev  = 1'b0;
   int   gaps[$];

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
         end else begin
            e = sb_q.pop_front();
            check("sb_bounced", int'(bounced_o), int'(e.b));
            check("sb_busy", int'(busy_o), int'(e.busy));
`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
            check("sb_glitch", int'(glitch_count_o), int'(e.g));
`endif
         end
         if (bounced_o != mon_prev) begin
            tog_total++;
            if (busy_o) begin
               if (last_tog >= 0) gaps.push_back(mon_cyc - last_tog);
               last_tog = mon_cyc;
            end
         end
         if (!busy_o) last_tog = -1;
         if (busy_o) busy_cnt++;
         mon_prev = bounced_o;
         mon_cyc++;
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      logic pat[9];
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      // Reset with input high
      resetn = 0; clean_i = 1; enable_i = 1;
      tick(5);
      check("reset_bounced", int'(bounced_o), 0);
      check("reset_busy", int'(busy_o), 0);
      resetn = 1;
      tick(1);
      check("release_busy", int'(busy_o), 1);
      check("release_bounced", int'(bounced_o), 1);
      tick(120);

      // Single rising edge
      clean_i = 0;
      tick(120);
      busy_cnt = 0;
      gaps.delete();
      clean_i = 1;
      tick(200);
      check("rise_busy_len", busy_cnt, int'(BC));
      check("rise_gaps_seen", int'(gaps.size() > 0), 1);
      foreach (gaps[i]) check_range("rise_gap", gaps[i], int'(MH) + 1, int'(MH) + (1 << HB));
      check("rise_settled", int'(bounced_o), 1);
      check("rise_idle", int'(busy_o), 0);

      // Mid-window reversal
      clean_i = 0;
      tick(120);
      busy_cnt = 0;
      clean_i = 1;
      tick(50);
      clean_i = 0;
      tick(200);
      check("rev_busy_len", busy_cnt, 150);
      check("rev_settled", int'(bounced_o), 0);

      // Bypass
      enable_i = 0;
      tick(2);
      busy_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         clean_i = pat[i];
         tick(1);
         check("bypass_follow", int'(bounced_o), int'(pat[i]));
      end
      check("bypass_busy", busy_cnt, 0);

      // Abort mid-window
      enable_i = 1;
      clean_i  = 0;
      tick(20);
      check("abort_in_window", int'(busy_o), 1);
      enable_i = 0;
      tick(1);
      check("abort_busy", int'(busy_o), 0);
      check("abort_bounced", int'(bounced_o), int'(clean_i));

      // Reset mid-window
      enable_i = 1;
      clean_i  = 1;
      tick(20);
      check("rst_in_window", int'(busy_o), 1);
      resetn = 0;
      tick(1);
      check("rst_mid_bounced", int'(bounced_o), 0);
      check("rst_mid_busy", int'(busy_o), 0);
      check("rst_mid_glitch", int'(glitch_count_o), 0);
      resetn  = 1;
      clean_i = 0;
      tick(5);

      // Randomized traffic, checked by the scoreboard
      for (int i = 0; i < 200; i++) begin
         resetn   = ($urandom_range(0, 99) >= 5);
         enable_i = ($urandom_range(0, 9) != 0);
         clean_i  = 1'($urandom_range(0, 1));
         tick(int'($urandom_range(1, 130)));
      end
      resetn = 1; enable_i = 1;
      tick(130);

`ifdef BOUNCE_GEN_GLITCH_COUNT_EN
      // Glitch counter: two full windows, then saturation
      resetn = 0; clean_i = 0; enable_i = 1;
      tick(3);
      tog_total = 0;
      resetn = 1;
      clean_i = 1;
      tick(120);
      clean_i = 0;
      tick(120);
      check("glitch_two_windows", int'(glitch_count_o), tog_total);
      for (int i = 0; i < 70000; i++) begin
         clean_i = ~clean_i;
         tick(1);
      end
      check("glitch_saturated", int'(glitch_count_o), 16'hFFFF);
      tick(120);
      check("glitch_hold_sat", int'(glitch_count_o), 16'hFFFF);
`endif

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
